// File: rtl/phase_scheduler.sv
// Green-phase scheduler for three mutually exclusive approaches (NN, NS, TH):
// latches sensor requests and grants green round-robin with min/max green, yellow and all-red.
module phase_scheduler #(
    parameter int TICK_DIV    = 10000,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 15,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_nn,
    input  logic       req_ns,
    input  logic       req_th,
    output logic [1:0] light_nn,
    output logic [1:0] light_ns,
    output logic [1:0] light_th,
    output logic [1:0] phase,
    output logic [7:0] sec_cnt
);

    typedef enum logic [1:0] {S_INIT, S_GREEN, S_YELLOW, S_ALLRED} state_t;

    localparam int              PRE_W      = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]      YEL_LAST   = 8'(T_YELLOW - 1);
    localparam logic [7:0]      AR_LAST    = 8'(T_ALLRED - 1);
    localparam logic [8:0]      MIN_G      = 9'(T_MIN_GREEN);
    localparam logic [8:0]      MAX_G      = 9'(T_MAX_GREEN);
    localparam logic [1:0]      LAMP_RED   = 2'b00;
    localparam logic [1:0]      LAMP_YEL   = 2'b01;
    localparam logic [1:0]      LAMP_GRN   = 2'b10;
    localparam logic [1:0]      PHASE_NONE = 2'b11;

    state_t           state, state_next;
    logic [1:0]       cur, cur_next;
    logic [2:0]       pend, pend_next;
    logic [PRE_W-1:0] pre;
    logic [2:0]       req;
    logic [2:0]       cur_mask;
    logic [2:0]       others_pend;
    logic             tick;
    logic [8:0]       sec_eff;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // First pending approach after prev in NN->NS->TH->NN order, prev itself last.
    function automatic logic [1:0] pick_after(input logic [1:0] prev, input logic [2:0] p);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = next_idx(prev);
        c2 = next_idx(c1);
        if (p[c1])      return c1;
        else if (p[c2]) return c2;
        return prev;
    endfunction

    function automatic logic [1:0] lamp(input state_t s, input logic [1:0] c, input logic [1:0] idx);
        if (c != idx)        return LAMP_RED;
        if (s == S_GREEN)    return LAMP_GRN;
        if (s == S_YELLOW)   return LAMP_YEL;
        return LAMP_RED;
    endfunction

    assign req         = {req_th, req_ns, req_nn};
    assign cur_mask    = 3'b001 << cur;
    assign others_pend = pend & ~cur_mask;
    assign tick        = (pre == PRE_LAST);
    // Seconds count as it will stand after this edge, so green limits hit on exact T*TICK_DIV cycles.
    assign sec_eff     = tick ? ({1'b0, sec_cnt} + 9'd1) : {1'b0, sec_cnt};

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        cur_next   = cur;
        case (state)
            S_INIT: begin
                if (tick && sec_cnt == AR_LAST) begin
                    state_next = S_GREEN;
                    cur_next   = (pend == 3'b000) ? 2'd0 : pick_after(2'd2, pend);
                end
            end
            S_GREEN: begin
                if (others_pend != 3'b000 &&
                    ((sec_eff >= MIN_G && !req[cur]) || sec_eff >= MAX_G))
                    state_next = S_YELLOW;
            end
            S_YELLOW: begin
                if (tick && sec_cnt == YEL_LAST) state_next = S_ALLRED;
            end
            S_ALLRED: begin
                if (tick && sec_cnt == AR_LAST) begin
                    state_next = S_GREEN;
                    cur_next   = pick_after(cur, pend);
                end
            end
            default: state_next = S_INIT;
        endcase

        pend_next = pend | (req & ~((state == S_GREEN) ? cur_mask : 3'b000));
        // Clearing on green entry wins over a request sampled on the same edge.
        if (state_next == S_GREEN && state != S_GREEN)
            pend_next = pend_next & ~(3'b001 << cur_next);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            cur      <= 2'd0;
            pend     <= 3'b000;
            pre      <= '0;
            sec_cnt  <= 8'd0;
            light_nn <= LAMP_RED;
            light_ns <= LAMP_RED;
            light_th <= LAMP_RED;
            phase    <= PHASE_NONE;
        end else begin
            state <= state_next;
            cur   <= cur_next;
            pend  <= pend_next;
            if (state_next != state) begin
                pre     <= '0;
                sec_cnt <= 8'd0;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick && sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
            end
            light_nn <= lamp(state_next, cur_next, 2'd0);
            light_ns <= lamp(state_next, cur_next, 2'd1);
            light_th <= lamp(state_next, cur_next, 2'd2);
            phase    <= (state_next == S_GREEN || state_next == S_YELLOW) ? cur_next : PHASE_NONE;
        end
    end

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: cycle-count reference model checked every cycle,
// plus hand-timed literal checkpoints for each scenario.
module tb_phase_scheduler;

    localparam int TD    = 4;
    localparam int T_MIN = 5;
    localparam int T_MAX = 15;
    localparam int T_YEL = 3;
    localparam int T_AR  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_nn = 1'b0, req_ns = 1'b0, req_th = 1'b0;
    logic [1:0] light_nn, light_ns, light_th, phase;
    logic [7:0] sec_cnt;

    int tests = 0;
    int fails = 0;
    int now   = 0;

    phase_scheduler #(
        .TICK_DIV(TD), .T_MIN_GREEN(T_MIN), .T_MAX_GREEN(T_MAX),
        .T_YELLOW(T_YEL), .T_ALLRED(T_AR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_nn(req_nn), .req_ns(req_ns), .req_th(req_th),
        .light_nn(light_nn), .light_ns(light_ns), .light_th(light_th),
        .phase(phase), .sec_cnt(sec_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: time measured as whole cycles spent in the current interval.
    typedef enum {M_INIT, M_GREEN, M_YELLOW, M_ALLRED} mstate_t;
    mstate_t    m_state = M_INIT;
    int         m_cur   = 0;
    int         m_cyc   = 0;
    logic [2:0] m_pend  = 3'b000;
    bit         m_valid = 1'b0;

    function automatic bit done_secs(input int cyc, input int secs);
        return (cyc + 1) >= secs * TD;
    endfunction

    always @(posedge clk) begin
        logic [2:0] req_v;
        logic [2:0] np;
        mstate_t    ns;
        int         nc;
        if (!rst_n) begin
            m_state = M_INIT; m_cur = 0; m_cyc = 0; m_pend = 3'b000; m_valid = 1'b1;
        end else begin
            req_v = {req_th, req_ns, req_nn};
            np = m_pend;
            for (int i = 0; i < 3; i++)
                if (req_v[i] && !(m_state == M_GREEN && m_cur == i)) np[i] = 1'b1;
            ns = m_state;
            nc = m_cur;
            case (m_state)
                M_INIT: if (done_secs(m_cyc, T_AR)) begin
                    ns = M_GREEN;
                    nc = m_pend[0] ? 0 : m_pend[1] ? 1 : m_pend[2] ? 2 : 0;
                end
                M_GREEN: begin
                    bit others;
                    others = 1'b0;
                    for (int i = 0; i < 3; i++) if (i != m_cur && m_pend[i]) others = 1'b1;
                    if (others && ((done_secs(m_cyc, T_MIN) && !req_v[m_cur]) || done_secs(m_cyc, T_MAX)))
                        ns = M_YELLOW;
                end
                M_YELLOW: if (done_secs(m_cyc, T_YEL)) ns = M_ALLRED;
                M_ALLRED: if (done_secs(m_cyc, T_AR)) begin
                    ns = M_GREEN;
                    for (int k = 3; k >= 1; k--) if (m_pend[(m_cur + k) % 3]) nc = (m_cur + k) % 3;
                end
                default: ns = M_INIT;
            endcase
            if (ns == M_GREEN && m_state != M_GREEN) np[nc] = 1'b0;
            m_cyc   = (ns != m_state) ? 0 : m_cyc + 1;
            m_state = ns;
            m_cur   = nc;
            m_pend  = np;
        end
    end

    function automatic int exp_lamp(input int idx);
        if (m_cur != idx) return 0;
        if (m_state == M_GREEN) return 2;
        if (m_state == M_YELLOW) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            int nonred;
            int es;
            es = m_cyc / TD;
            if (es > 255) es = 255;
            check("light_nn", 32'(light_nn), exp_lamp(0));
            check("light_ns", 32'(light_ns), exp_lamp(1));
            check("light_th", 32'(light_th), exp_lamp(2));
            check("phase", 32'(phase),
                  (m_state == M_GREEN || m_state == M_YELLOW) ? m_cur : 3);
            check("sec_cnt", 32'(sec_cnt), es);
            check("pend", 32'(dut.pend), 32'(m_pend));
            nonred = int'(light_nn != 2'b00) + int'(light_ns != 2'b00) + int'(light_th != 2'b00);
            check("single_nonred", 32'(nonred <= 1), 1);
        end
    end

    task automatic goto(input int k);
        repeat (k - now) @(negedge clk);
        now = k;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_nn = 1'b0; req_ns = 1'b0; req_th = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        now = 0;
    endtask

    initial begin
        // 1: no requests, NN green held, sec_cnt saturates.
        do_reset();
        check("t1_reset_phase", 32'(phase), 3);
        check("t1_reset_sec", 32'(sec_cnt), 0);
        goto(3);   check("t1_init_red", 32'(light_nn), 0);
        goto(4);   check("t1_nn_green", 32'(light_nn), 2); check("t1_phase0", 32'(phase), 0);
        goto(204); check("t1_nn_held", 32'(light_nn), 2);
        goto(1023); check("t1_sec254", 32'(sec_cnt), 254);
        goto(1024); check("t1_sec255", 32'(sec_cnt), 255);
        goto(1100); check("t1_sec_sat", 32'(sec_cnt), 255);

        // 2: TH pulse at sec 2, NN ends at MIN.
        do_reset();
        goto(12); check("t2_sec2", 32'(sec_cnt), 2);
        req_th = 1'b1;
        goto(13); req_th = 1'b0;
        goto(23); check("t2_nn_still_green", 32'(light_nn), 2);
        goto(24); check("t2_nn_yellow", 32'(light_nn), 1);
        goto(35); check("t2_yellow_end", 32'(light_nn), 1);
        goto(36); check("t2_allred", 32'(phase), 3);
        goto(39); check("t2_allred_end", 32'(light_th), 0);
        goto(40); check("t2_th_green", 32'(light_th), 2); check("t2_pend_th", 32'(dut.pend[2]), 0);

        // 3: req_nn held and req_ns held, NN green runs to MAX.
        do_reset();
        req_nn = 1'b1; req_ns = 1'b1;
        goto(4);  check("t3_nn_green", 32'(light_nn), 2);
        goto(63); check("t3_nn_green_last", 32'(light_nn), 2);
        goto(64); check("t3_nn_yellow", 32'(light_nn), 1);
        goto(76); check("t3_allred", 32'(phase), 3);
        goto(80); check("t3_ns_green", 32'(light_ns), 2);
        req_nn = 1'b0; req_ns = 1'b0;

        // 4: all requests held, round-robin with 60-cycle greens.
        do_reset();
        req_nn = 1'b1; req_ns = 1'b1; req_th = 1'b1;
        goto(4);   check("t4_g1_nn", 32'(phase), 0);
        goto(80);  check("t4_g2_ns", 32'(phase), 1);
        goto(156); check("t4_g3_th", 32'(phase), 2);
        goto(232); check("t4_g4_nn", 32'(phase), 0);
        req_nn = 1'b0; req_ns = 1'b0; req_th = 1'b0;

        // 5: one-cycle reset during NS yellow.
        do_reset();
        goto(10); req_ns = 1'b1;
        goto(11); req_ns = 1'b0;
        goto(40); check("t5_ns_green", 32'(light_ns), 2);
        goto(42); req_th = 1'b1;
        goto(43); req_th = 1'b0;
        goto(60); check("t5_ns_yellow", 32'(light_ns), 1);
        goto(65); rst_n = 1'b0;
        goto(66);
        check("t5_rst_ns_red", 32'(light_ns), 0);
        check("t5_rst_phase", 32'(phase), 3);
        check("t5_rst_pend", 32'(dut.pend), 0);
        rst_n = 1'b1;
        now = 0;
        goto(3); check("t5_still_red", 32'(light_nn), 0);
        goto(4); check("t5_nn_green", 32'(light_nn), 2);

        // 6: req_ns on the edge NS enters green must not leave it pending.
        do_reset();
        goto(10); req_ns = 1'b1;
        goto(11); req_ns = 1'b0;
        goto(39); req_ns = 1'b1;
        goto(40); req_ns = 1'b0;
        check("t6_ns_green", 32'(light_ns), 2);
        goto(41); check("t6_pend_ns_clear", 32'(dut.pend[1]), 0);
        goto(45); req_th = 1'b1;
        goto(46); req_th = 1'b0;
        goto(60);  check("t6_ns_yellow", 32'(light_ns), 1);
        goto(76);  check("t6_th_green", 32'(phase), 2);
        goto(150); check("t6_th_held", 32'(light_th), 2); check("t6_ns_red", 32'(light_ns), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Green-phase scheduler for the intersection's three mutually exclusive approaches: Norton northbound (NN), Norton southbound (NS) and Thevenin (TH). It latches vehicle-sensor requests and grants green round-robin with minimum/maximum green, yellow and all-red clearance. Interval timing comes from an internal prescaler on the 10 kHz system clock. Its 2-bit light codes drive the existing `semaforo` lamp decoders directly.

## Interface
- `TICK_DIV`, 10000: clk cycles per 1 s tick; ≥2.
- `T_MIN_GREEN`, 5: minimum green, seconds; 1..255.
- `T_MAX_GREEN`, 15: green limit while others wait, seconds; `T_MIN_GREEN`..255.
- `T_YELLOW`, 3: yellow, seconds; 1..255.
- `T_ALLRED`, 1: all-red clearance, seconds; 1..255.

- `clk` in 1: system clock, 10 kHz nominal; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset; one clock, no async paths.
- `req_nn`, `req_ns`, `req_th` in 1 each: sensor request levels, synchronous to `clk`.
- `light_nn`, `light_ns`, `light_th` out 2 each: 2'b00 red, 2'b01 yellow, 2'b10 green; 2'b11 never driven.
- `phase` out 2: approach holding green/yellow (0 NN, 1 NS, 2 TH); 2'b11 in INIT/ALLRED.
- `sec_cnt` out 8: whole seconds elapsed in current state, saturating at 255.

## Operation
- States: INIT, GREEN, YELLOW, ALLRED. `cur` (2 bits) holds the served approach in GREEN/YELLOW.
- Pending flags `pend[2:0]`: `pend[i]` sets on any cycle `req_i`=1, unless approach i is in GREEN. Clears on the edge i enters GREEN. Clear wins over set on that same edge.
- INIT, the reset state: all lights red. After `T_ALLRED` s, go to GREEN with `cur` = first pending in order NN, NS, TH. If none is pending, use NN.
- GREEN: `light_cur` = green, others red. Go to YELLOW when either condition holds:
  - sec ≥ `T_MIN_GREEN`, another approach pending, and `req_cur` = 0;
  - sec ≥ `T_MAX_GREEN` and another approach pending.
- GREEN with no other pending: hold green indefinitely; `sec_cnt` saturates.
- YELLOW: `light_cur` = yellow, others red. After `T_YELLOW` s, go to ALLRED.
- ALLRED: all red. After `T_ALLRED` s, go to GREEN with `cur` = first pending approach after the previous `cur`, cyclic NN→NS→TH→NN. At least one is always pending here, because GREEN is left only when another approach is pending.
- Never two non-red lights; never green directly after green without YELLOW+ALLRED.

## Timing
- Prescaler `pre` counts 0..`TICK_DIV`-1; tick when `pre`=`TICK_DIV`-1. `sec_cnt` increments on tick, saturating.
- `pre` and `sec_cnt` clear to 0 on every state change, so a T-second state lasts exactly T·`TICK_DIV` cycles.
- Timed exits fire on the edge ending the cycle where tick=1 and `sec_cnt`=T-1.
- GREEN exit conditions are evaluated every cycle once sec ≥ `T_MIN_GREEN`. A request that arrives late therefore ends green on the next edge after its `pend` flag registers.
- Outputs are registered and decoded from the state register. Lights change on the same edge as the state.
- `req`→`pend` latency: 1 cycle. `pend`→GREEN exit: 1 further cycle.
- Reset values: all `light_*` = 2'b00, `phase` = 2'b11, `sec_cnt` = 0, `pend` = 0, state INIT, `pre` = 0, `cur` = 0.
- Reset is sampled every edge and overrides everything. `rst_n` low mid-GREEN or mid-YELLOW gives all red on the next edge, with no yellow.
- First NN green occurs `T_ALLRED`·`TICK_DIV` cycles after the first edge with `rst_n`=1.

## Test plan
All scenarios use `TICK_DIV`=4, MIN=5, MAX=15, YELLOW=3, ALLRED=1.
1. Reset release, no requests -> all red for 4 cycles, then `light_nn`=green, `phase`=0, held for 200 cycles; `sec_cnt` saturates at 255 after 1020 cycles.
2. NN green, `req_th` pulsed 1 cycle at sec 2, `req_nn`=0 -> NN yellow at 20 cycles into green, all red after 12 more, TH green after 4 more; `pend[2]` cleared.
3. NN green with `req_nn` held 1, `req_ns`=1 -> NN green lasts exactly 60 cycles (MAX), then yellow 12, all-red 4, NS green.
4. All three requests held continuously -> grant order NN, NS, TH, NN…; each green 60 cycles; never two non-red lights in any cycle.
5. `rst_n`=0 for 1 cycle during NS yellow -> next edge all lights red, `phase`=3, `pend`=0; NN green 4 cycles after release.
6. `req_ns` asserted on the edge NS enters green -> `pend[1]`=0 afterwards; no repeated NS grant without a new request.
